// File: rtl/noc_pkg.sv
// Shared flit format for the XY-routed bufferless mesh: field widths, offsets,
// the packed flit struct and its constructor.
package noc_pkg;

   localparam int X_SIZE     = 2;
   localparam int Y_SIZE     = 2;
   localparam int DATA_W     = 8;
   localparam int DEST_W     = X_SIZE + Y_SIZE;
   localparam int SRC_W      = X_SIZE + Y_SIZE;
   localparam int DEST_Y_LSB = 0;
   localparam int DEST_X_LSB = Y_SIZE;
   localparam int SRC_LSB    = X_SIZE + Y_SIZE;
   localparam int DATA_LSB   = SRC_LSB + SRC_W;
   localparam int FLIT_W     = DATA_LSB + DATA_W;

   typedef enum logic {
      INJ_IDLE = 1'b0,
      INJ_SEND = 1'b1
   } inj_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
      logic [X_SIZE-1:0] dest_x;
      logic [Y_SIZE-1:0] dest_y;
   } flit_t;

   // dest and src are {x,y} pairs, exactly as they sit in the flit
   function automatic flit_t make_flit(input logic [DATA_W-1:0] data,
                                       input logic [SRC_W-1:0]  src,
                                       input logic [DEST_W-1:0] dest);
      flit_t f;
      f = '0;
      f[DEST_Y_LSB +: Y_SIZE] = dest[Y_SIZE-1:0];
      f[DEST_X_LSB +: X_SIZE] = dest[DEST_W-1:Y_SIZE];
      f[SRC_LSB +: SRC_W]     = src;
      f[DATA_LSB +: DATA_W]   = data;
      return f;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO exposing the head and the entry behind it, so the
// reader can move straight on to the next entry in the cycle it pops.
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [WIDTH-1:0] o_next,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_cnt
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;
   logic [AW-1:0]    w_rd_nxt;
   logic             w_push;
   logic             w_pop;

   assign o_full   = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty  = (r_cnt == '0);
   assign w_push   = i_push & ~o_full;
   assign w_pop    = i_pop & ~o_empty;
   assign w_rd_nxt = r_rd_ptr + AW'(1);
   assign o_head   = r_mem[r_rd_ptr];
   assign o_next   = r_mem[w_rd_nxt];
   assign o_cnt    = r_cnt;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/noc_pe_injector.sv
// PE-side transmit interface: buffers result bytes and multicasts each one as a
// flit per configured destination. NI_INJ_STALL_CNT_EN adds a back-pressure counter.
module noc_pe_injector
   import noc_pkg::*;
#(
   parameter int x_coord     = 3,
   parameter int y_coord     = 1,
   parameter int x_size      = 2,
   parameter int y_size      = 2,
   parameter int data_width  = 8,
   parameter int total_width = 2*x_size + 2*y_size + data_width,
   parameter int fifo_depth  = 4,
   parameter int num_dest    = 4,
   parameter logic [num_dest*(x_size+y_size)-1:0] dest_list =
      {2'd3,2'd1, 2'd2,2'd3, 2'd1,2'd2, 2'd0,2'd0}
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [data_width-1:0]         i_res_data,
   input  logic                          i_res_valid,
   output logic                          o_res_ready,
   output logic [total_width-1:0]        o_data_sw,
   output logic                          o_valid_sw,
   input  logic                          i_ready_sw,
   output logic [$clog2(fifo_depth):0]   o_fifo_cnt,
`ifdef NI_INJ_STALL_CNT_EN
   output logic [15:0]                   o_stall_cnt,
`endif
   output logic                          o_busy
);

   localparam int DW = x_size + y_size;
   localparam int CW = $clog2(fifo_depth) + 1;
   localparam int IW = (num_dest > 1) ? $clog2(num_dest) : 1;
   localparam logic [DW-1:0] SRC = {x_coord[x_size-1:0], y_coord[y_size-1:0]};

   inj_state_t              r_state, w_state_next;
   logic [IW-1:0]           r_dest_idx, w_idx_next, w_fidx;
   logic                    r_valid, w_valid_next;
   logic [total_width-1:0]  r_data, w_flit;
   logic                    w_load, w_use_next, w_pop;
   logic [data_width-1:0]   w_head, w_next, w_fdata;
   logic [DW-1:0]           w_dest;
   logic                    w_full, w_empty;
   logic [CW-1:0]           w_cnt;

   noc_sync_fifo #(.WIDTH(data_width), .DEPTH(fifo_depth)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (i_res_valid),
      .i_wdata (i_res_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_cnt   (w_cnt)
   );

   assign w_fdata = w_use_next ? w_next : w_head;
   assign w_dest  = dest_list[w_fidx*DW +: DW];

   generate
      if (x_size == X_SIZE && y_size == Y_SIZE && data_width == DATA_W) begin : g_pkg_flit
         assign w_flit = make_flit(w_fdata, SRC, w_dest);
      end else begin : g_gen_flit
         assign w_flit = {w_fdata, SRC, w_dest};
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_dest_idx;
      w_valid_next = r_valid;
      w_load       = 1'b0;
      w_use_next   = 1'b0;
      w_fidx       = '0;
      w_pop        = 1'b0;
      case (r_state)
         INJ_IDLE: begin
            if (!w_empty) begin
               w_load       = 1'b1;
               w_valid_next = 1'b1;
               w_idx_next   = '0;
               w_state_next = INJ_SEND;
            end else begin
               w_valid_next = 1'b0;
            end
         end
         INJ_SEND: begin
            if (i_ready_sw) begin
               if (r_dest_idx != IW'(num_dest - 1)) begin
                  w_idx_next = r_dest_idx + IW'(1);
                  w_fidx     = r_dest_idx + IW'(1);
                  w_load     = 1'b1;
               end else begin
                  // last destination taken: retire the head, chain into the next one if present
                  w_pop      = 1'b1;
                  w_idx_next = '0;
                  if (w_cnt > CW'(1)) begin
                     w_load     = 1'b1;
                     w_use_next = 1'b1;
                  end else begin
                     w_valid_next = 1'b0;
                     w_state_next = INJ_IDLE;
                  end
               end
            end
         end
         default: w_state_next = INJ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= INJ_IDLE;
         r_dest_idx <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_dest_idx <= w_idx_next;
         r_valid    <= w_valid_next;
         if (w_load) r_data <= w_flit;
      end
   end

`ifdef NI_INJ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_stall_cnt <= '0;
      else if (r_valid && !i_ready_sw && r_stall_cnt != 16'hFFFF)
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end
   assign o_stall_cnt = r_stall_cnt;
`endif

   assign o_res_ready = ~w_full;
   assign o_data_sw   = r_data;
   assign o_valid_sw  = r_valid;
   assign o_fifo_cnt  = w_cnt;
   assign o_busy      = (r_state != INJ_IDLE) | ~w_empty;

endmodule

// File: tb/tb_noc_pe_injector.sv
// Bench for noc_pe_injector: a queue-based reference of the result FIFO and the
// multicast flit stream, directed scenarios, then randomized traffic.
module tb_noc_pe_injector;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  i_res_data = '0;
   logic        i_res_valid = 1'b0;
   logic        i_ready_sw = 1'b0;
   logic        o_res_ready;
   logic [15:0] o_data_sw;
   logic        o_valid_sw;
   logic [2:0]  o_fifo_cnt;
   logic        o_busy;
`ifdef NI_INJ_STALL_CNT_EN
   logic [15:0] o_stall_cnt;
`endif

   always #5 clk = ~clk;

   noc_pe_injector dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_res_data  (i_res_data),
      .i_res_valid (i_res_valid),
      .o_res_ready (o_res_ready),
      .o_data_sw   (o_data_sw),
      .o_valid_sw  (o_valid_sw),
      .i_ready_sw  (i_ready_sw),
      .o_fifo_cnt  (o_fifo_cnt),
`ifdef NI_INJ_STALL_CNT_EN
      .o_stall_cnt (o_stall_cnt),
`endif
      .o_busy      (o_busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: results held (head in flight), flits of the head already taken
   logic [7:0]  q_res[$];
   int          sent = 0;
   logic        exp_valid = 1'b0;
   logic [15:0] exp_data = '0;
   int          exp_stall = 0;
   logic [15:0] got[$];

   // Destination nibbles {x,y} for entries 0..3; source {3,1} is nibble D
   logic [3:0] dest_nib [4] = '{4'h0, 4'h6, 4'hB, 4'hD};

   function automatic logic [15:0] flit(input logic [7:0] d, input int k);
      return {d, 4'hD, dest_nib[k]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Compare and predict on the falling edge; inputs only change 2ns after a rising edge
   initial begin
      int  cnt;
      bit  push;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            q_res.delete();
            sent      = 0;
            exp_valid = 1'b0;
            exp_stall = 0;
            check("rst_valid", o_valid_sw, 0);
            check("rst_cnt",   o_fifo_cnt, 0);
            check("rst_busy",  o_busy,     0);
            check("rst_data",  o_data_sw,  0);
         end else begin
            check("valid", o_valid_sw, exp_valid);
            if (exp_valid) check("data", o_data_sw, exp_data);
            check("cnt",   o_fifo_cnt,  q_res.size());
            check("ready", o_res_ready, q_res.size() < 4);
            check("busy",  o_busy,      exp_valid || q_res.size() > 0);
`ifdef NI_INJ_STALL_CNT_EN
            check("stall", o_stall_cnt, exp_stall);
`endif
            if (o_valid_sw && i_ready_sw) begin
               got.push_back(o_data_sw);
               $display("flit 0x%04h taken t=%0t", o_data_sw, $time);
            end
            cnt  = q_res.size();
            push = i_res_valid && (cnt < 4);
            if (exp_valid && !i_ready_sw && exp_stall < 65535) exp_stall++;
            if (exp_valid) begin
               if (i_ready_sw) begin
                  sent++;
                  if (sent == 4) begin
                     void'(q_res.pop_front());
                     sent = 0;
                     if (cnt > 1) exp_data = flit(q_res[0], 0);
                     else         exp_valid = 1'b0;
                  end else begin
                     exp_data = flit(q_res[0], sent);
                  end
               end
            end else if (cnt > 0) begin
               exp_valid = 1'b1;
               exp_data  = flit(q_res[0], 0);
               sent      = 0;
            end
            if (push) q_res.push_back(i_res_data);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_res(input logic [7:0] d);
      int n = 0;
      i_res_valid = 1'b1;
      i_res_data  = d;
      while (!o_res_ready && n < 200) begin
         step();
         n++;
      end
      check("push_accept", o_res_ready, 1);
      step();
      i_res_valid = 1'b0;
   endtask

   task automatic wait_nib(input logic [3:0] nib);
      int n = 0;
      while (!(o_valid_sw && o_data_sw[3:0] == nib) && n < 200) begin
         step();
         n++;
      end
      check("wait_flit", {o_valid_sw, o_data_sw[3:0]}, {1'b1, nib});
   endtask

   logic [15:0] exp2 [8] = '{16'h11D0, 16'h11D6, 16'h11DB, 16'h11DD,
                             16'h22D0, 16'h22D6, 16'h22DB, 16'h22DD};

   initial begin
      repeat (3) step();
      rstn = 1'b1;
      step();

      // single result, ready always high
      got.delete();
      i_ready_sw = 1'b1;
      push_res(8'hA5);
      check("lat_edge_n", o_valid_sw, 0);
      step();
      check("lat_edge_n1", o_valid_sw, 1);
      check("t1_f0", o_data_sw, 16'hA5D0);
      step(); check("t1_f1", o_data_sw, 16'hA5D6);
      step(); check("t1_f2", o_data_sw, 16'hA5DB);
      step(); check("t1_f3", o_data_sw, 16'hA5DD);
      step();
      check("t1_idle_valid", o_valid_sw, 0);
      check("t1_idle_busy",  o_busy, 0);
      check("t1_count", got.size(), 4);

      // two results back to back
      got.delete();
      push_res(8'h11);
      push_res(8'h22);
      repeat (12) step();
      check("t2_count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) check("t2_flit", got[i], exp2[i]);

      // back-pressure at destination index 2
      got.delete();
      push_res(8'h33);
      wait_nib(4'hB);
      i_ready_sw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold", {o_valid_sw, o_data_sw}, {1'b1, 16'h33DB});
      end
      i_ready_sw = 1'b1;
      step();
      check("t3_resume", o_data_sw, 16'h33DD);
      repeat (4) step();
      check("t3_count", got.size(), 4);
      if (got.size() == 4) check("t3_third", got[2], 16'h33DB);

      // fill the FIFO under back-pressure
      got.delete();
      i_ready_sw = 1'b0;
      for (int i = 0; i < 4; i++) push_res(8'h40 + 8'(i));
      check("t4_full_cnt",   o_fifo_cnt, 4);
      check("t4_full_ready", o_res_ready, 0);
      i_res_valid = 1'b1;
      i_res_data  = 8'h44;
      repeat (3) step();
      check("t4_stalled_cnt", o_fifo_cnt, 4);
      i_ready_sw = 1'b1;
      push_res(8'h44);
      repeat (24) step();
      check("t4_count", got.size(), 20);
      if (got.size() == 20) begin
         check("t4_first", got[0],  16'h40D0);
         check("t4_mid",   got[15], 16'h43DD);
         check("t4_fifth", got[16], 16'h44D0);
      end

      // asynchronous reset while the third flit is pending
      got.delete();
      push_res(8'h55);
      wait_nib(4'hB);
      rstn = 1'b0;
      #1;
      check("t5_rst_valid", o_valid_sw, 0);
      check("t5_rst_cnt",   o_fifo_cnt, 0);
      step();
      rstn = 1'b1;
      repeat (10) step();
      check("t5_no_residual", got.size(), 2);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         i_res_valid = 1'($urandom_range(0, 1));
         i_res_data  = 8'($urandom);
         i_ready_sw  = ($urandom_range(0, 3) != 0);
         step();
      end
      i_res_valid = 1'b0;
      i_ready_sw  = 1'b1;
      repeat (40) step();
      check("rand_drained", o_busy, 0);

`ifdef NI_INJ_STALL_CNT_EN
      i_ready_sw = 1'b0;
      push_res(8'h77);
      repeat (70000) step();
      check("stall_sat", o_stall_cnt, 16'hFFFF);
      repeat (5) step();
      check("stall_hold", o_stall_cnt, 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/noc_pe_injector.md
Name: noc_pe_injector

Overview:
- PE-side transmit network interface for the XY-routed bufferless mesh.
- Accepts neuron result bytes on a valid/ready port and buffers them in a small FIFO.
- For each buffered result, emits one flit per configured destination into the local switch's PE input port (i_data_pe / i_valid_pe / o_ready_pe), holding each flit stable under switch back-pressure.
- This is the initiator for the switch PE ingress, the counterpart of the switch-to-neuron delivery path.

Parameters:
- x_coord, 'd3: own switch X coordinate, used as the source field.
- y_coord, 'd1: own switch Y coordinate, used as the source field.
- x_size, 2: width of each X coordinate field.
- y_size, 2: width of each Y coordinate field.
- data_width, 8: payload width.
- total_width, 2*x_size+2*y_size+data_width: flit width (16 at defaults).
- fifo_depth, 4: result FIFO entries; must be a power of 2 and >= 2.
- num_dest, 4: number of destinations per result; >= 1.
- dest_list, {2'd3,2'd1, 2'd2,2'd3, 2'd1,2'd2, 2'd0,2'd0}: packed num_dest*(x_size+y_size) bits; entry i sits at bits [i*4+3 : i*4] as {x,y}, entry 0 in the LSBs.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: asynchronous active-low reset.
- i_res_data, input, data_width: neuron result payload.
- i_res_valid, input, 1: result valid.
- o_res_ready, output, 1: FIFO can accept a result.
- o_data_sw, output, total_width: flit to switch i_data_pe.
- o_valid_sw, output, 1: flit valid, to switch i_valid_pe.
- i_ready_sw, input, 1: switch o_ready_pe (combinational in the switch).
- o_fifo_cnt, output, $clog2(fifo_depth)+1: FIFO occupancy.
- o_busy, output, 1: FSM not IDLE or FIFO not empty.

Behaviour:
- Flit layout, LSB first:
  - [y_size-1:0] = dest y.
  - [x_size+y_size-1:y_size] = dest x (bits [3:2] at defaults).
  - next x_size+y_size bits = source {x_coord, y_coord}.
  - top data_width bits = payload.
- Reset: asynchronous. All of the following clear immediately on rstn low:
  - o_valid_sw=0, o_data_sw=0, o_fifo_cnt=0, o_busy=0.
  - FIFO pointers cleared, FSM=IDLE, dest_idx=0.
  - Any partially sent multicast is discarded.
- Push rule:
  - o_res_ready = ~full, combinational from the count.
  - Push on posedge when i_res_valid & o_res_ready.
  - When full, no push is accepted even if a pop happens in the same cycle (no bypass).
- Transfer rule:
  - A flit is taken on posedge when o_valid_sw & i_ready_sw.
  - While o_valid_sw=1 and ~i_ready_sw, o_data_sw and o_valid_sw hold unchanged.
- FSM, two states:
  - IDLE, FIFO non-empty: register the flit for head entry with dest_idx=0, set o_valid_sw=1, go to SEND.
  - IDLE, FIFO empty: o_valid_sw=0.
  - SEND, ~i_ready_sw: hold.
  - SEND, i_ready_sw, dest_idx<num_dest-1: dest_idx+1, register the next flit for the same head (back-to-back, no bubble).
  - SEND, i_ready_sw, dest_idx==num_dest-1: pop head, dest_idx=0.
    - If count>1 at that edge: register the flit for the new head's dest 0, stay in SEND.
    - Otherwise: o_valid_sw=0, go to IDLE.
- Latency: result pushed at edge N gives o_valid_sw=1 after edge N+1 (FIFO empty, IDLE).
- Sustained throughput: one flit per cycle while i_ready_sw=1.
- Simultaneous push and pop, not full: count is unchanged and both pointers advance.
- Pointer wrap is modulo fifo_depth.
- A destination equal to (x_coord,y_coord) is sent normally; the switch loops it back.
- Must not depend on i_ready_sw when o_valid_sw=0.
- num_dest=1: every accepted flit pops.

Optional Feature:
- Macro: NI_INJ_STALL_CNT_EN.
- Defined: adds output o_stall_cnt, 16 bits.
  - Increments each cycle o_valid_sw & ~i_ready_sw.
  - Saturates at 16'hFFFF.
  - Clears on reset only.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - coordinate widths and flit field offsets (DEST_Y_LSB, DEST_X_LSB, SRC_LSB, DATA_LSB).
  - the flit_t packed struct.
  - function make_flit(data, src, dest).
- One sub-module, noc_sync_fifo: parameterised width/depth, async active-low reset, push/pop/full/empty/count. The injector FSM stays in the top.

Test Plan:
- Defaults; push 0xA5 once, i_ready_sw=1 → o_valid_sw high after edge N+1; flits 0xA5D0, 0xA5D6, 0xA5DB, 0xA5DD on 4 consecutive cycles; then IDLE, o_busy=0.
- Push 0x11 and 0x22 back-to-back, i_ready_sw=1 → 8 consecutive flits, 0x11D0..0x11DD then 0x22D0..0x22DD, with no bubble between results.
- i_ready_sw=0 for 5 cycles mid-multicast at dest_idx=2 → 0x??DB held stable for all 5 cycles; resumes with 0x??DD; no flit lost or duplicated.
- i_ready_sw=0, push 5 results → o_res_ready=0 after 4 entries, o_fifo_cnt=4, fifth result stalled; release → all 16 flits delivered in order, then fifth result accepted.
- rstn low for 1 cycle while the third flit is pending → o_valid_sw=0 immediately, o_fifo_cnt=0; after release no residual flits are emitted.
- With NI_INJ_STALL_CNT_EN, hold i_ready_sw=0 for 70000 cycles with a flit valid → o_stall_cnt=16'hFFFF and it stays there.
